// File: rtl/score_event_arbiter.sv
// score_event_arbiter: buffers per-source score events and issues them to score_alu one per cycle,
// round-robin over additive sources, ghosts as bursts, doubling only once additive work has drained.
module score_event_arbiter #(
    parameter int CNT_W      = 3,
    parameter int GHOST_ADDS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       hold,
    output logic [1:0] alu_select,
    output logic       alu_enable,
    output logic       busy,
    output logic       pending_any,
    output logic [3:0] overflow
);
    typedef enum logic {IDLE, BURST} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [3:0] BURST_LOAD = 4'(GHOST_ADDS - 1);

    state_t state, next_state;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0] nz, cand, gnt, burst_left, next_burst;
    logic [1:0] rr, next_rr, p1, p2, pick, issue_sel;
    logic issue, found;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_nz
        assign nz[i] = |cnt[i];
    end

    // Only the additive sources take part in round-robin; slot 3 is never a candidate
    assign cand  = {1'b0, nz[2:0]};
    assign p1    = inc3(rr);
    assign p2    = inc3(p1);
    assign found = cand[rr] | cand[p1] | cand[p2];
    assign pick  = cand[rr] ? rr : cand[p1] ? p1 : p2;

    assign busy        = state == BURST;
    assign pending_any = |nz | busy;

    always_comb begin
        next_state = state;
        next_burst = burst_left;
        next_rr    = rr;
        gnt        = '0;
        issue      = 1'b0;
        issue_sel  = 2'b10;
        if (!hold) begin
            if (state == BURST) begin
                issue      = 1'b1;
                next_burst = burst_left - 4'd1;
                if (burst_left == 4'd1) next_state = IDLE;
            end else if (found) begin
                issue      = 1'b1;
                issue_sel  = pick;
                gnt[pick]  = 1'b1;
                next_rr    = inc3(pick);
                if (pick == 2'd2) begin
                    next_burst = BURST_LOAD;
                    if (BURST_LOAD != 4'd0) next_state = BURST;
                end
            end else if (nz[3]) begin
                issue     = 1'b1;
                issue_sel = 2'b11;
                gnt[3]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            burst_left <= '0;
            rr         <= '0;
            alu_enable <= 1'b0;
            alu_select <= 2'b00;
        end else begin
            state      <= next_state;
            burst_left <= next_burst;
            rr         <= next_rr;
            alu_enable <= issue;
            if (issue) alu_select <= issue_sel;
        end
    end

    // A request and a grant on the same source in one cycle cancel out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !gnt[i]) begin
                    if (cnt[i] == MAX) overflow[i] <= 1'b1;
                    else cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (gnt[i] && !req[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_score_event_arbiter.sv
// tb_score_event_arbiter: directed vector table plus hand sequences for ghost bursts with hold and reset.
module tb_score_event_arbiter;
    logic clk = 1'b0, reset_n = 1'b0, hold = 1'b0;
    logic [3:0] req = 4'h0;
    logic [1:0] alu_select;
    logic alu_enable, busy, pending_any;
    logic [3:0] overflow;

    logic rn3 = 1'b0, hold3 = 1'b0;
    logic [3:0] req3 = 4'h0;
    logic [1:0] sel3;
    logic en3, busy3, pend3;
    logic [3:0] ovf3;

    int checks = 0, errors = 0;

    score_event_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .hold(hold),
        .alu_select(alu_select), .alu_enable(alu_enable), .busy(busy),
        .pending_any(pending_any), .overflow(overflow)
    );

    score_event_arbiter #(.CNT_W(3), .GHOST_ADDS(3)) dut3 (
        .clk(clk), .reset_n(rn3), .req(req3), .hold(hold3),
        .alu_select(sel3), .alu_enable(en3), .busy(busy3),
        .pending_any(pend3), .overflow(ovf3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       hold;
        logic       en;
        logic [1:0] sel;
        logic       busy;
        logic       pend;
        logic [3:0] ovf;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic h, input logic e,
                       input logic [1:0] s, input logic b, input logic p, input logic [3:0] o);
        vec_t v;
        v.rst = r; v.req = q; v.hold = h; v.en = e; v.sel = s; v.busy = b; v.pend = p; v.ovf = o;
        tv.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e_exp [7];
        logic b_exp [7];
        logic h_seq [7];
        int n;
        // single pellet, then reset, then simultaneous sources
        add(1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0111, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'h0);
        // deferred doubling
        add(1'b0, 4'b1000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0001, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b1001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'h0);
        // saturation: nine pellets under hold, then drain
        for (int k = 0; k < 9; k++)
            add(1'b0, 4'b0001, 1'b1, 1'b0, 2'b11, 1'b0, k > 0, {3'b000, k >= 8});
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 4'h1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 4'h1);
        for (int k = 1; k <= 7; k++)
            add(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, k < 7, 4'h1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h1);

        step();
        step();
        chk("reset.en", {3'b0, alu_enable}, 4'h0);
        chk("reset.sel", {2'b0, alu_select}, 4'h0);
        chk("reset.busy", {3'b0, busy}, 4'h0);
        chk("reset.pend", {3'b0, pending_any}, 4'h0);
        chk("reset.ovf", overflow, 4'h0);

        foreach (tv[k]) begin
            chk($sformatf("v%0d.en", k), {3'b0, alu_enable}, {3'b0, tv[k].en});
            chk($sformatf("v%0d.sel", k), {2'b0, alu_select}, {2'b0, tv[k].sel});
            chk($sformatf("v%0d.busy", k), {3'b0, busy}, {3'b0, tv[k].busy});
            chk($sformatf("v%0d.pend", k), {3'b0, pending_any}, {3'b0, tv[k].pend});
            chk($sformatf("v%0d.ovf", k), overflow, tv[k].ovf);
            reset_n = !tv[k].rst;
            req     = tv[k].req;
            hold    = tv[k].hold;
            step();
        end

        // hold for two cycles starting with the first +10 of a 3-add ghost burst
        rn3 = 1'b1;
        req3 = 4'b0100;
        step();
        req3 = 4'b0000;
        step();
        e_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        b_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        h_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n = 0;
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("hb%0d.en", c), {3'b0, en3}, {3'b0, e_exp[c]});
            chk($sformatf("hb%0d.busy", c), {3'b0, busy3}, {3'b0, b_exp[c]});
            if (en3) begin
                n++;
                chk($sformatf("hb%0d.sel", c), {2'b0, sel3}, 4'h2);
            end
            hold3 = h_seq[c];
            step();
        end
        chk("hb.strobes", 4'(n), 4'd3);

        // asynchronous reset in the middle of a burst with pellets queued
        req3 = 4'b0100;
        step();
        req3 = 4'b0001;
        step();
        step();
        req3 = 4'b0000;
        chk("rb.busy_before", {3'b0, busy3}, 4'h1);
        chk("rb.en_before", {3'b0, en3}, 4'h1);
        #2 rn3 = 1'b0;
        #1;
        chk("rb.en", {3'b0, en3}, 4'h0);
        chk("rb.sel", {2'b0, sel3}, 4'h0);
        chk("rb.busy", {3'b0, busy3}, 4'h0);
        chk("rb.pend", {3'b0, pend3}, 4'h0);
        chk("rb.ovf", ovf3, 4'h0);
        step();
        rn3 = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (en3) n++;
        end
        chk("rb.strobes", 4'(n), 4'd0);
        chk("rb.pend_after", {3'b0, pend3}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_event_arbiter.md
# score_event_arbiter

Sequencer in front of the `score_alu` datapath. It collects one-cycle score-event pulses from four game-logic requesters and buffers them per source. It then issues them one per cycle as `alu_select`/`alu_enable` commands, round-robin among the additive sources. Ghost events expand into a multi-cycle burst, and the score-doubling event is deferred until all additive work has drained.

## Interface
- `CNT_W`, 3, width of each per-source pending counter (max `2^CNT_W-1` = 7 queued events per source)
- `GHOST_ADDS`, 2, number of consecutive +10 ops issued per ghost event (legal range 1..15)

- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `req`  in  4  one-cycle event pulses: [0] pellet (+1, sel 00), [1] power pellet (+5, sel 01), [2] ghost eaten (`GHOST_ADDS`× +10, sel 10), [3] level clear (double, sel 11)
- `hold`  in  1  pause: no new op issued while high
- `alu_select`  out  2  op code to `score_alu`, registered
- `alu_enable`  out  1  one-cycle op strobe to `score_alu`, registered
- `busy`  out  1  high while in BURST
- `pending_any`  out  1  any counter nonzero or BURST active
- `overflow`  out  4  sticky per-source drop flags

## Operation
- **Counters.** There is one `CNT_W`-bit pending counter per source.
  - A `req[i]` pulse increments counter i.
  - A grant of source i decrements counter i.
  - Request and grant on the same source in the same cycle: the count is unchanged.
- **Saturation.**
  - A request arriving at max count with no simultaneous grant is dropped, and `overflow[i]` is set.
  - `overflow` bits are cleared only by reset.
- **State machine** has two states, IDLE and BURST.
- **IDLE, `hold`=0.**
  - Candidates are sources 0..2 with nonzero count.
  - Round-robin pointer `rr` (reset 0): grant the first candidate at or after `rr`, in order `rr`, `rr`+1, `rr`+2 mod 3. Then set `rr` = granted+1 mod 3.
  - If sources 0..2 all have zero count and counter 3 is nonzero: grant source 3 (doubling). `rr` is unchanged.
  - Granting source 2 loads `burst_left` = `GHOST_ADDS`-1. If that value is nonzero, go to BURST.
- **BURST.**
  - Each cycle with `hold`=0: issue sel 10, decrement `burst_left`. Return to IDLE when the count reaches 0.
  - No other source is granted during BURST.
  - `hold`=1 pauses the burst; it does not abort it.
- **Output registers.**
  - A grant in cycle N produces `alu_enable`=1 and the matching `alu_select` in cycle N+1.
  - With no grant, `alu_enable`=0 and `alu_select` holds its last value.
- **Combinational outputs.**
  - `busy` = (state==BURST).
  - `pending_any` = OR of counters, or BURST.
- **Reset, including mid-burst:**
  - counters = 0, `rr` = 0, state = IDLE, `burst_left` = 0
  - `alu_select` = 00, `alu_enable` = 0
  - `overflow` = 0000, `busy` = 0, `pending_any` = 0
  - Queued events are discarded.

## Timing
- **Latency.** A `req` pulse in cycle N updates the counter at the end of N. The grant can happen in N+1, so `alu_enable` is high in N+2 at the earliest.
- **Throughput.** At most one op per cycle. `alu_enable` can stay high for consecutive cycles.
- **Hold.** `hold` sampled high in cycle N means `alu_enable`=0 in N+1. Counters keep accepting requests.
- **Request pulses.** A pulse held high for k cycles counts as k events.
- **Doubling order.** A doubling never issues while any additive count is nonzero or BURST is active. Additive events arriving while doubling is pending are serviced first.

## Test plan
- **Single pellet.** `req`=0001 in cycle 0 -> `alu_enable`=1, `alu_select`=00 in cycle 2 only. `pending_any` is 1 in cycle 1 and 0 from cycle 2.
- **Simultaneous sources.** `req`=0111 in cycle 0 -> selects 00, 01, 10, 10 in cycles 2–5. `busy`=1 in cycle 4. `alu_enable`=0 in cycle 6. Connected `score_alu` reads 26.
- **Deferred doubling.** `req`=1000 in cycle 0, then `req`=0001 in cycle 1 -> sel 11 issued in cycle 2. Then `req`=1001 together -> sel 00 issued before sel 11.
- **Saturation.** Drive 9 pellet pulses with `hold`=1 -> counter is 7 and `overflow[0]`=1. Release `hold` -> exactly 7 consecutive sel 00 strobes. The flag stays set.
- **Hold mid-burst.** Use `GHOST_ADDS`=3. Assert `hold` for 2 cycles right after the first +10 -> exactly 3 sel 10 strobes total. `busy` stays high through the pause.
- **Reset mid-burst.** Drop `reset_n` asynchronously during BURST with pellets queued -> all outputs go to their reset values immediately. No strobes follow after release until a new `req`.
